// File: rtl/dma_word_bridge_if.sv
// CPU word port and DMA read/write channel bundle for dma_word_bridge.
interface dma_word_bridge_if #(
   parameter int WORD_WIDTH     = 32,
   parameter int LINE_WIDTH     = 512,
   parameter int ADDR_WIDTH     = 64,
   parameter int CPU_ADDR_WIDTH = 16,
   parameter int SIZE_WIDTH     = 43
);
   logic                      host_init;
   logic [ADDR_WIDTH-1:0]     base_addr;
   logic                      ready;
   logic [1:0]                op;
   logic [CPU_ADDR_WIDTH-1:0] io_address;
   logic [WORD_WIDTH-1:0]     data_in;
   logic [WORD_WIDTH-1:0]     data_out;
   logic                      rd_valid;
   logic                      tx_done;

   logic [ADDR_WIDTH-1:0]     rd_addr;
   logic [SIZE_WIDTH-1:0]     rd_size;
   logic                      rd_go;
   logic                      empty;
   logic                      rd_en;
   logic [LINE_WIDTH-1:0]     rd_data;
   logic                      rd_done;

   logic [ADDR_WIDTH-1:0]     wr_addr;
   logic [SIZE_WIDTH-1:0]     wr_size;
   logic                      wr_go;
   logic                      full;
   logic                      wr_en;
   logic [LINE_WIDTH-1:0]     wr_data;
   logic                      wr_done;

   modport slave (
      input  host_init, base_addr, op, io_address, data_in,
      input  empty, rd_data, rd_done, full, wr_done,
      output ready, data_out, rd_valid, tx_done,
      output rd_addr, rd_size, rd_go, rd_en,
      output wr_addr, wr_size, wr_go, wr_en, wr_data
   );

   modport master (
      output host_init, base_addr, op, io_address, data_in,
      output empty, rd_data, rd_done, full, wr_done,
      input  ready, data_out, rd_valid, tx_done,
      input  rd_addr, rd_size, rd_go, rd_en,
      input  wr_addr, wr_size, wr_go, wr_en, wr_data
   );
endinterface

// File: rtl/dma_word_bridge.sv
// Word-addressed CPU port backed by a one-line buffer that fills
// from a DMA read channel and writes through on a DMA write channel.
module dma_word_bridge #(
   parameter int WORD_WIDTH     = 32,
   parameter int LINE_WIDTH     = 512,
   parameter int ADDR_WIDTH     = 64,
   parameter int CPU_ADDR_WIDTH = 16,
   parameter int SIZE_WIDTH     = 43
) (
   input logic              clk,
   input logic              rst,
   dma_word_bridge_if.slave bus
);
   localparam int WPL   = LINE_WIDTH / WORD_WIDTH;
   localparam int SHIFT = $clog2(WPL);
   localparam int LSH   = $clog2(LINE_WIDTH / 8);

   localparam logic [1:0] OP_RD = 2'b01;
   localparam logic [1:0] OP_WR = 2'b10;

   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_WAIT, RESP, WR_REQ, WR_WAIT, WR_DONE
   } state_e;

   state_e                    state_q, state_d;
   logic                      init_q, init_d;
   logic                      valid_q, valid_d;
   logic [CPU_ADDR_WIDTH-1:0] tag_q, tag_d;
   logic [LINE_WIDTH-1:0]     buf_q, buf_d;
   logic [ADDR_WIDTH-1:0]     base_q, base_d;
   logic [CPU_ADDR_WIDTH-1:0] line_q, line_d;
   logic [CPU_ADDR_WIDTH-1:0] sel_q, sel_d;
   logic [WORD_WIDTH-1:0]     wdata_q, wdata_d;
   logic                      is_wr_q, is_wr_d;
   logic                      ready_q, ready_d;
   logic [WORD_WIDTH-1:0]     data_out_q, data_out_d;
   logic                      rd_valid_q, rd_valid_d;
   logic                      tx_done_q, tx_done_d;
   logic [ADDR_WIDTH-1:0]     rd_addr_q, rd_addr_d;
   logic                      rd_go_q, rd_go_d;
   logic                      rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
   logic                      wr_go_q, wr_go_d;
   logic                      wr_en_q, wr_en_d;
   logic [LINE_WIDTH-1:0]     wr_data_q, wr_data_d;

   logic [CPU_ADDR_WIDTH-1:0] in_sel;
   logic [CPU_ADDR_WIDTH-1:0] in_line;
   logic [ADDR_WIDTH-1:0]     in_addr;
   logic                      hit;
   logic                      unused_rd_done;

   assign in_sel  = bus.io_address & CPU_ADDR_WIDTH'(WPL - 1);
   assign in_line = bus.io_address >> SHIFT;
   assign in_addr = base_q + (ADDR_WIDTH'(in_line) << LSH);
   assign hit     = valid_q && (tag_q == in_line);

   assign unused_rd_done = bus.rd_done;

   always_comb begin
      state_d    = state_q;
      init_d     = init_q;
      valid_d    = valid_q;
      tag_d      = tag_q;
      buf_d      = buf_q;
      base_d     = base_q;
      line_d     = line_q;
      sel_d      = sel_q;
      wdata_d    = wdata_q;
      is_wr_d    = is_wr_q;
      data_out_d = data_out_q;
      rd_addr_d  = rd_addr_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      rd_valid_d = 1'b0;
      tx_done_d  = 1'b0;
      rd_go_d    = 1'b0;
      rd_en_d    = 1'b0;
      wr_go_d    = 1'b0;
      wr_en_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!bus.host_init && init_q &&
                (bus.op == OP_RD || bus.op == OP_WR)) begin
               line_d  = in_line;
               sel_d   = in_sel;
               wdata_d = bus.data_in;
               is_wr_d = (bus.op == OP_WR);
               if (!hit) begin
                  rd_addr_d = in_addr;
                  rd_go_d   = 1'b1;
                  state_d   = RD_REQ;
               end else if (bus.op == OP_RD) begin
                  data_out_d = buf_q[in_sel*WORD_WIDTH +: WORD_WIDTH];
                  rd_valid_d = 1'b1;
                  tx_done_d  = 1'b1;
                  state_d    = RESP;
               end else begin
                  wr_addr_d = in_addr;
                  wr_go_d   = 1'b1;
                  state_d   = WR_REQ;
               end
            end
         end
         RD_REQ: state_d = RD_WAIT;
         RD_WAIT: begin
            // rd_en was issued last cycle, so rd_data holds the popped line
            if (rd_en_q) begin
               buf_d   = bus.rd_data;
               tag_d   = line_q;
               valid_d = 1'b1;
               if (is_wr_q) begin
                  wr_addr_d = rd_addr_q;
                  wr_go_d   = 1'b1;
                  state_d   = WR_REQ;
               end else begin
                  data_out_d = bus.rd_data[sel_q*WORD_WIDTH +: WORD_WIDTH];
                  rd_valid_d = 1'b1;
                  tx_done_d  = 1'b1;
                  state_d    = RESP;
               end
            end else if (!bus.empty) begin
               rd_en_d = 1'b1;
            end
         end
         RESP: state_d = IDLE;
         WR_REQ: begin
            buf_d[sel_q*WORD_WIDTH +: WORD_WIDTH] = wdata_q;
            wr_data_d = buf_d;
            state_d   = WR_WAIT;
         end
         WR_WAIT: begin
            if (!bus.full) begin
               wr_en_d = 1'b1;
               state_d = WR_DONE;
            end
         end
         WR_DONE: begin
            if (bus.wr_done) begin
               tx_done_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (bus.host_init) begin
         valid_d = 1'b0;
         base_d  = bus.base_addr;
         init_d  = 1'b1;
      end
      ready_d = init_d && (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         init_q     <= 1'b0;
         valid_q    <= 1'b0;
         tag_q      <= '0;
         buf_q      <= '0;
         base_q     <= '0;
         line_q     <= '0;
         sel_q      <= '0;
         wdata_q    <= '0;
         is_wr_q    <= 1'b0;
         ready_q    <= 1'b0;
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
         tx_done_q  <= 1'b0;
         rd_addr_q  <= '0;
         rd_go_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_go_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         init_q     <= init_d;
         valid_q    <= valid_d;
         tag_q      <= tag_d;
         buf_q      <= buf_d;
         base_q     <= base_d;
         line_q     <= line_d;
         sel_q      <= sel_d;
         wdata_q    <= wdata_d;
         is_wr_q    <= is_wr_d;
         ready_q    <= ready_d;
         data_out_q <= data_out_d;
         rd_valid_q <= rd_valid_d;
         tx_done_q  <= tx_done_d;
         rd_addr_q  <= rd_addr_d;
         rd_go_q    <= rd_go_d;
         rd_en_q    <= rd_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_go_q    <= wr_go_d;
         wr_en_q    <= wr_en_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign bus.ready    = ready_q;
   assign bus.data_out = data_out_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.tx_done  = tx_done_q;
   assign bus.rd_addr  = rd_addr_q;
   assign bus.rd_size  = SIZE_WIDTH'(1);
   assign bus.rd_go    = rd_go_q;
   assign bus.rd_en    = rd_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_size  = SIZE_WIDTH'(1);
   assign bus.wr_go    = wr_go_q;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_data  = wr_data_q;
endmodule
